// File: rtl/uart_pkg.sv
// Shared UART constants: reference clock, default oversampling and baud divisors.
package uart_pkg;

   localparam int CLK_HZ          = 100_000_000;
   localparam int OVERSAMPLE_DEF  = 16;

   // Divisor = CLK_HZ / (baud * OVERSAMPLE_DEF), split into integer and 1/16ths
   localparam int DIV_9600_INT    = 651;
   localparam int DIV_9600_FRAC   = 1;
   localparam int DIV_115200_INT  = 54;
   localparam int DIV_115200_FRAC = 4;

endpackage

// File: rtl/baud_prescaler.sv
// Fractional-N down-counter producing the raw oversample event for baud_tick_gen.
module baud_prescaler #(
   parameter int DIV_W       = 16,
   parameter int FRAC_W      = 4,
   parameter int DEF_DIV_INT = 651
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              restart,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              os_evt
);

   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [FRAC_W:0]   sum;

   always_comb begin
      sum    = {1'b0, acc_q} + {1'b0, div_frac};
      os_evt = en && !restart && (cnt_q == '0);
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      if (restart) begin
         cnt_d = div_int - DIV_W'(1);
         acc_d = '0;
      end else if (os_evt) begin
         // Accumulator overflow stretches the period now starting by one cycle
         acc_d = sum[FRAC_W-1:0];
         cnt_d = div_int - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
      end else if (en) begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= DIV_W'(DEF_DIV_INT - 1);
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: shadow/active divisor registers, oversample phase counter
// and registered os_tick / bit_tick strobes around a fractional prescaler.
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
   parameter int DEF_DIV_INT  = DIV_9600_INT,
   parameter int DEF_DIV_FRAC = DIV_9600_FRAC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              restart,
   input  logic              half,
   input  logic              cfg_we,
   input  logic [DIV_W-1:0]  cfg_int,
   input  logic [FRAC_W-1:0] cfg_frac,
   output logic              os_tick,
   output logic              bit_tick
);

   localparam int PH_W = $clog2(OVERSAMPLE);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);

   logic [DIV_W-1:0]  s_int_q, s_int_d, a_int_q, a_int_d;
   logic [FRAC_W-1:0] s_frac_q, s_frac_d, a_frac_q, a_frac_d;
   logic              pend_q, pend_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic              os_tick_q, os_tick_d, bit_tick_q, bit_tick_d;
   logic [DIV_W-1:0]  cfg_int_cl, eff_int;
   logic [FRAC_W-1:0] eff_frac;
   logic              os_evt;

   baud_prescaler #(
      .DIV_W       (DIV_W),
      .FRAC_W      (FRAC_W),
      .DEF_DIV_INT (DEF_DIV_INT)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .restart  (restart),
      .div_int  (eff_int),
      .div_frac (eff_frac),
      .os_evt   (os_evt)
   );

   always_comb begin
      cfg_int_cl = (cfg_int < DIV_W'(2)) ? DIV_W'(2) : cfg_int;
      // Divisor the prescaler reloads with: a pending write wins over the active one
      eff_int  = pend_q ? s_int_q  : a_int_q;
      eff_frac = pend_q ? s_frac_q : a_frac_q;
      if (restart && cfg_we) begin
         eff_int  = cfg_int_cl;
         eff_frac = cfg_frac;
      end

      s_int_d  = s_int_q;
      s_frac_d = s_frac_q;
      a_int_d  = a_int_q;
      a_frac_d = a_frac_q;
      pend_d   = pend_q;
      ph_d     = ph_q;

      if (cfg_we) begin
         s_int_d  = cfg_int_cl;
         s_frac_d = cfg_frac;
         pend_d   = 1'b1;
      end

      if (restart) begin
         a_int_d  = eff_int;
         a_frac_d = eff_frac;
         pend_d   = 1'b0;
         ph_d     = half ? PH_MID : '0;
      end else if (pend_q && (!en || os_evt)) begin
         // A write landing in the same cycle stays pending for the next reload
         a_int_d  = s_int_q;
         a_frac_d = s_frac_q;
         pend_d   = cfg_we;
      end

      if (os_evt) begin
         ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
      end

      os_tick_d  = os_evt;
      bit_tick_d = os_evt && (ph_q == PH_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_int_q    <= DIV_W'(DEF_DIV_INT);
         s_frac_q   <= FRAC_W'(DEF_DIV_FRAC);
         a_int_q    <= DIV_W'(DEF_DIV_INT);
         a_frac_q   <= FRAC_W'(DEF_DIV_FRAC);
         pend_q     <= 1'b0;
         ph_q       <= '0;
         os_tick_q  <= 1'b0;
         bit_tick_q <= 1'b0;
      end else begin
         s_int_q    <= s_int_d;
         s_frac_q   <= s_frac_d;
         a_int_q    <= a_int_d;
         a_frac_q   <= a_frac_d;
         pend_q     <= pend_d;
         ph_q       <= ph_d;
         os_tick_q  <= os_tick_d;
         bit_tick_q <= bit_tick_d;
      end
   end

   assign os_tick  = os_tick_q;
   assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen; edge k means "sampled 1 ns after the k-th rising edge".
module tb_baud_tick_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic        restart;
   logic        half;
   logic        cfg_we;
   logic [15:0] cfg_int;
   logic [3:0]  cfg_frac;
   logic        os_tick;
   logic        bit_tick;

   int n_vec;
   int n_err;

   baud_tick_gen dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .restart  (restart),
      .half     (half),
      .cfg_we   (cfg_we),
      .cfg_int  (cfg_int),
      .cfg_frac (cfg_frac),
      .os_tick  (os_tick),
      .bit_tick (bit_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The edge consumed here becomes edge 0 of the following scenario
   task automatic do_restart(input logic [15:0] di, input logic [3:0] df, input logic h);
      restart  = 1'b1;
      cfg_we   = 1'b1;
      cfg_int  = di;
      cfg_frac = df;
      half     = h;
      en       = 1'b1;
      tick();
      restart  = 1'b0;
      cfg_we   = 1'b0;
      half     = 1'b0;
   endtask

   task automatic test_reset();
      logic exp_os;
      rst = 1'b1; en = 1'b1; restart = 1'b0; half = 1'b0;
      cfg_we = 1'b0; cfg_int = 16'd0; cfg_frac = 4'd0;
      tick();
      tick();
      n_vec++;
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: os=%b bit=%b, want 0/0", os_tick, bit_tick);
      end
      rst = 1'b0;
      for (int k = 1; k <= 660; k++) begin
         tick();
         exp_os = (k == 651);
         n_vec++;
         if (os_tick !== exp_os || bit_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_default_div edge %0d: os=%b bit=%b, want %b/0", k, os_tick, bit_tick, exp_os);
         end
      end
      $display("test_reset done (default divisor 651)");
   endtask

   task automatic test_basic();
      logic exp_os, exp_bit;
      do_restart(16'd4, 4'd0, 1'b0);
      for (int k = 1; k <= 140; k++) begin
         tick();
         exp_os  = (k % 4 == 0);
         exp_bit = (k == 64) || (k == 128);
         n_vec++;
         if (os_tick !== exp_os || bit_tick !== exp_bit) begin
            n_err++;
            $display("FAIL basic_div4 edge %0d: os=%b bit=%b, want %b/%b", k, os_tick, bit_tick, exp_os, exp_bit);
         end
      end
      $display("test_basic done (div 4/0, bit at 64 and 128)");
   endtask

   task automatic test_frac();
      int   exp_next, step, n_ticks, t_first, t_33;
      logic exp_os;
      do_restart(16'd4, 4'd8, 1'b0);
      // Ticks at 4, 8, 13, 17, 22, ...: first two periods 4, then 5/4 alternating
      exp_next = 4; step = 4; n_ticks = 0; t_first = 0; t_33 = 0;
      for (int k = 1; k <= 160; k++) begin
         tick();
         exp_os = (k == exp_next);
         if (exp_os) begin
            exp_next = exp_next + step;
            step     = (step == 4) ? 5 : 4;
         end
         if (os_tick === 1'b1) begin
            n_ticks++;
            if (n_ticks == 1)  t_first = k;
            if (n_ticks == 33) t_33 = k;
         end
         n_vec++;
         if (os_tick !== exp_os) begin
            n_err++;
            $display("FAIL frac_4p5 edge %0d: os=%b, want %b", k, os_tick, exp_os);
         end
      end
      n_vec++;
      if (t_33 - t_first !== 144) begin
         n_err++;
         $display("FAIL frac_32_ticks: span=%0d cycles, want 144", t_33 - t_first);
      end
      $display("test_frac done (div 4/8, 32 ticks span %0d)", t_33 - t_first);
   endtask

   task automatic test_half();
      logic exp_os, exp_bit;
      do_restart(16'd4, 4'd0, 1'b1);
      for (int k = 1; k <= 100; k++) begin
         tick();
         exp_os  = (k % 4 == 0);
         exp_bit = (k == 32) || (k == 96);
         n_vec++;
         if (os_tick !== exp_os || bit_tick !== exp_bit) begin
            n_err++;
            $display("FAIL half_phase edge %0d: os=%b bit=%b, want %b/%b", k, os_tick, bit_tick, exp_os, exp_bit);
         end
      end
      $display("test_half done (bit at 32 and 96)");
   endtask

   task automatic test_en_pause();
      int   kk;
      logic exp_os, exp_bit;
      do_restart(16'd4, 4'd0, 1'b0);
      for (int k = 1; k <= 140; k++) begin
         en = !(k >= 7 && k <= 9);
         tick();
         kk      = (k <= 6) ? k : ((k <= 9) ? -1 : k - 3);
         exp_os  = (kk > 0) && (kk % 4 == 0);
         exp_bit = (kk > 0) && (kk % 64 == 0);
         n_vec++;
         if (os_tick !== exp_os || bit_tick !== exp_bit) begin
            n_err++;
            $display("FAIL en_pause edge %0d: os=%b bit=%b, want %b/%b", k, os_tick, bit_tick, exp_os, exp_bit);
         end
      end
      en = 1'b1;
      $display("test_en_pause done (3-cycle pause, bit at 67 and 131)");
   endtask

   task automatic test_cfg_write();
      logic exp_os;
      do_restart(16'd4, 4'd0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         cfg_we   = (k == 6) || (k == 27);
         cfg_int  = (k == 27) ? 16'd0 : 16'd6;
         cfg_frac = 4'd0;
         tick();
         exp_os = (k == 4) || (k == 8) || (k == 14) || (k == 20) || (k == 26) ||
                  (k == 32) || (k == 34) || (k == 36) || (k == 38) || (k == 40);
         n_vec++;
         if (os_tick !== exp_os) begin
            n_err++;
            $display("FAIL cfg_write edge %0d: os=%b, want %b", k, os_tick, exp_os);
         end
      end
      cfg_we = 1'b0;
      $display("test_cfg_write done (4 -> 6 -> clamped 2)");
   endtask

   task automatic test_reset_override();
      logic exp_os;
      do_restart(16'd4, 4'd0, 1'b0);
      for (int k = 1; k <= 10; k++) tick();
      rst = 1'b1; restart = 1'b1; cfg_we = 1'b1; cfg_int = 16'd4; cfg_frac = 4'd0; half = 1'b1;
      tick();
      n_vec++;
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) begin
         n_err++;
         $display("FAIL rst_override_state: os=%b bit=%b, want 0/0", os_tick, bit_tick);
      end
      rst = 1'b0; restart = 1'b0; cfg_we = 1'b0; half = 1'b0;
      for (int k = 1; k <= 655; k++) begin
         tick();
         exp_os = (k == 651);
         n_vec++;
         if (os_tick !== exp_os || bit_tick !== 1'b0) begin
            n_err++;
            $display("FAIL rst_override edge %0d: os=%b bit=%b, want %b/0", k, os_tick, bit_tick, exp_os);
         end
      end
      $display("test_reset_override done (reset beats restart and cfg_we)");
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_frac();
      test_half();
      test_en_pause();
      test_cfg_write();
      test_reset_override();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART, successor to the fixed-divisor bit counter. It produces an oversample strobe (`os_tick`) and a bit strobe (`bit_tick`) from a runtime-programmable integer-plus-fractional divisor. It supports restart with optional half-bit phase for RX start-bit centring. TX and RX each instantiate one copy.

## Interface
- `DIV_W`, 16: width of integer divisor (cycles per oversample tick).
- `FRAC_W`, 4: width of fractional divisor; resolution 1/2^FRAC_W cycle.
- `OVERSAMPLE`, 16: oversample ticks per bit; even, ≥ 4.
- `DEF_DIV_INT`, 651: integer divisor after reset (100 MHz / 9600 / 16).
- `DEF_DIV_FRAC`, 1: fractional divisor after reset.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset; synchronous, active-high; dominates every other input.
- `en` in 1: count enable; low freezes counters and forces ticks low.
- `restart` in 1: one-cycle pulse; realigns counters.
- `half` in 1: sampled with `restart`; 1 = start phase at mid-bit.
- `cfg_we` in 1: write `cfg_int`/`cfg_frac` into the shadow registers.
- `cfg_int` in DIV_W: new integer divisor.
- `cfg_frac` in FRAC_W: new fractional divisor.
- `os_tick` out 1: registered one-cycle oversample strobe.
- `bit_tick` out 1: registered one-cycle bit strobe; coincides with an `os_tick`.

## Operation
- Active divisor (`a_int`, `a_frac`) drives counting; shadow (`s_int`, `s_frac`) holds pending config.
- Clamp: any `cfg_int` < 2 is stored as 2.
- Prescaler `cnt` (DIV_W) counts down. Fractional accumulator `acc` (FRAC_W) adds `a_frac` on every reload. The carry out of that FRAC_W-bit add lengthens the next period by one cycle. Average period = `a_int + a_frac/2^FRAC_W` cycles.
- On an enabled cycle with `cnt==0`:
  - `os_tick` is set next edge.
  - `{carry, acc} <= acc + a_frac`.
  - `cnt <= a_int - 1 + carry`.
  - Active ← shadow, if a shadow write is pending.
- Otherwise, on an enabled cycle, `cnt` decrements.
- Phase counter `ph` (clog2(OVERSAMPLE) bits) increments on each os_tick event and wraps from OVERSAMPLE-1 to 0. `bit_tick` is set on the event where `ph==OVERSAMPLE-1`.
- `restart`:
  - Active ← shadow; `cnt <= a_int_new - 1`; `acc <= 0`.
  - `ph <= half ? OVERSAMPLE/2 : 0`.
  - Ticks are low in the following cycle.
- `en` low: `cnt`, `acc` and `ph` hold; active ← shadow immediately if a write is pending; both ticks are 0.
- Priority: `rst` > `restart` > `cfg_we` apply > count. `restart` together with `cfg_we` in the same cycle loads the new `cfg_*` values directly.
- `rst` state:
  - Shadow and active = DEF_DIV_INT/DEF_DIV_FRAC.
  - `cnt` = DEF_DIV_INT-1; `acc` = 0; `ph` = 0.
  - `os_tick` = 0; `bit_tick` = 0; no write pending.

## Timing
- With `en` high continuously after `rst`/`restart` (edge 0), `frac=0` and divisor D: `os_tick` is high after edges D, 2D, 3D, …
- `bit_tick` (half=0): high after edge D·OVERSAMPLE, then every D·OVERSAMPLE cycles.
- `bit_tick` (half=1): first high after edge D·OVERSAMPLE/2, then every D·OVERSAMPLE cycles.
- Each `en` low cycle delays all later ticks by exactly one cycle.
- A config write while running takes effect at the first reload after the write. The current period always completes at the old divisor.
- Latency from internal event to tick output is one register stage; no combinational path from inputs to outputs.

## Structure
- Shared `uart_pkg`:
  - `OVERSAMPLE_DEF`.
  - Divisor constants `DIV_9600_INT/FRAC` = 651/1 and `DIV_115200_INT/FRAC` = 54/4 at `CLK_HZ` = 100_000_000.
  - `CLK_HZ` itself.
- One sub-module, `baud_prescaler`: `cnt`, `acc` and reload/carry logic, emitting the raw oversample event. The top level adds shadow registers, `ph` and the output registers.

## Test plan
- Reset, then `en`=1, `cfg` 4/0, OVERSAMPLE=16: `os_tick` after edges 4, 8, 12…; `bit_tick` only after edge 64, then 128.
- `cfg` 4/8 (FRAC_W=4): `os_tick` intervals alternate 4, 5, 4, 5; 32 os ticks take exactly 144 cycles.
- `restart` with `half`=1 and `cfg` 4/0: first `bit_tick` after edge 32, next after edge 96.
- `en` low for 3 cycles mid-period: every subsequent tick shifts by exactly 3 cycles; both ticks are 0 while `en` is low.
- `cfg_we` of 6 while running at 4: the current period ends at 4; the following period is 6. `cfg_int`=0 yields period 2.
- `rst` asserted together with `restart`/`cfg_we` mid-count: next cycle shows reset state; divisor is 651/1; no tick for 651 cycles.
